// File: rtl/spi_master_pkg.sv
// SPI master shared definitions: FSM encoding and word-length limits.
package spi_master_pkg;

  localparam int MAX_WORD_LEN     = 32;
  localparam int DEFAULT_WORD_LEN = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  // Zero selects the default length; oversize requests clamp to the widest word.
  function automatic logic [5:0] eff_len(
    input logic [5:0] wl,
    input int         mx
  );
    if (wl == 6'd0) return 6'(DEFAULT_WORD_LEN);
    if (int'(wl) > mx) return 6'(mx);
    return wl;
  endfunction

endpackage

// File: rtl/spi_master_clkgen.sv
// SCLK generator: half-period counter plus leading/trailing edge strobes.
module spi_master_clkgen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       park,
  input  logic       cpol,
  input  logic       cpol_l,
  input  logic [7:0] div,
  output logic       sclk,
  output logic       lead,
  output logic       trail
);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       tick;

  always_comb begin
    tick   = run && (cnt_q == div);
    cnt_d  = 8'd0;
    if (run && !tick) cnt_d = cnt_q + 8'd1;
    sclk_d = sclk_q;
    if (park) sclk_d = cpol;
    else if (tick) sclk_d = ~sclk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 8'd0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign sclk  = sclk_q;
  assign lead  = tick && (sclk_q == cpol_l);
  assign trail = tick && (sclk_q != cpol_l);

endmodule

// File: rtl/spi_master_engine.sv
// SPI master shift engine: pops TX words, shifts them out, pushes RX words.
module spi_master_engine #(
  parameter int MAX_WORD_LEN = spi_master_pkg::MAX_WORD_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic                    lsb_first,
  input  logic                    loopback,
  input  logic [7:0]              clk_div,
  input  logic [5:0]              word_len,
  input  logic [MAX_WORD_LEN-1:0] tx_data,
  input  logic                    tx_valid,
  output logic                    tx_pop,
  input  logic                    rx_full,
  output logic [MAX_WORD_LEN-1:0] rx_data,
  output logic                    rx_push,
  output logic                    busy,
  output logic                    done_intr,
  output logic                    rx_overrun,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);

  import spi_master_pkg::*;

  localparam int IW = $clog2(MAX_WORD_LEN);

  state_e                  state_q, state_d;
  logic [5:0]              n_q, n_d, n_new;
  logic [MAX_WORD_LEN-1:0] tx_q, tx_d;
  logic [MAX_WORD_LEN-1:0] rx_sh_q, rx_sh_d;
  logic [MAX_WORD_LEN-1:0] rx_data_q, rx_data_d;
  logic                    cpol_q, cpol_d, cpha_q, cpha_d;
  logic                    lsb_q, lsb_d, lb_q, lb_d;
  logic [7:0]              div_q, div_d;
  logic [6:0]              edge_q, edge_d;
  logic                    mosi_q, mosi_d;
  logic                    tx_pop_q, tx_pop_d, busy_q, busy_d;
  logic                    done_q, done_d, push_q, push_d;
  logic                    ovr_q, ovr_d;
  logic [5:0]              idx, tidx;
  logic [IW-1:0]           lpos, rpos, tpos;
  logic                    last, smp;
  logic                    run, park, lead, trail;

  assign run  = (state_q == SHIFT) && enable;
  assign park = (state_q == IDLE) || (state_q == LOAD) ||
                ((state_q == SHIFT) && !enable);

  spi_master_clkgen u_clkgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .park   (park),
    .cpol   (cpol),
    .cpol_l (cpol_q),
    .div    (div_q),
    .sclk   (spi_sclk),
    .lead   (lead),
    .trail  (trail)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    tx_d      = tx_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    lb_d      = lb_q;
    div_d     = div_q;
    edge_d    = edge_q;
    rx_sh_d   = rx_sh_q;
    mosi_d    = mosi_q;
    rx_data_d = rx_data_q;
    n_new     = eff_len(word_len, MAX_WORD_LEN);
    lpos      = lsb_first ? '0 : IW'(n_new - 6'd1);
    idx       = edge_q[6:1];
    tidx      = idx + {5'd0, ~cpha_q};
    rpos      = lsb_q ? IW'(idx) : IW'(n_q - 6'd1 - idx);
    tpos      = lsb_q ? IW'(tidx) : IW'(n_q - 6'd1 - tidx);
    last      = edge_q == ({n_q, 1'b0} - 7'd1);
    smp       = lb_q ? mosi_q : spi_miso;
    unique case (state_q)
      IDLE: if (enable && tx_valid) state_d = LOAD;
      LOAD: begin
        if (!enable) state_d = IDLE;
        else begin
          state_d = SHIFT;
          n_d     = n_new;
          tx_d    = tx_data;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          lb_d    = loopback;
          div_d   = clk_div;
          edge_d  = 7'd0;
          rx_sh_d = '0;
          if (!cpha) mosi_d = tx_data[lpos];
        end
      end
      SHIFT: begin
        if (!enable) state_d = IDLE;
        else if (lead || trail) begin
          edge_d = edge_q + 7'd1;
          if (cpha_q ? trail : lead) rx_sh_d[rpos] = smp;
          // Mode 0 never shifts on the closing edge so MOSI keeps the last bit.
          if (cpha_q ? lead : (trail && !last)) mosi_d = tx_q[tpos];
          if (last) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_pop_d = (state_q == IDLE) && (state_d == LOAD);
    busy_d   = state_d != IDLE;
    done_d   = state_d == DONE;
    push_d   = done_d && !rx_full;
    ovr_d    = done_d && rx_full;
    if (push_d) rx_data_d = rx_sh_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= 6'd0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      lb_q      <= 1'b0;
      div_q     <= 8'd0;
      edge_q    <= 7'd0;
      mosi_q    <= 1'b0;
      tx_pop_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      push_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      lb_q      <= lb_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      mosi_q    <= mosi_d;
      tx_pop_q  <= tx_pop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      push_q    <= push_d;
      ovr_q     <= ovr_d;
    end
  end

  assign tx_pop     = tx_pop_q;
  assign busy       = busy_q;
  assign done_intr  = done_q;
  assign rx_push    = push_q;
  assign rx_overrun = ovr_q;
  assign rx_data    = rx_data_q;
  assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine with a TX FIFO model and pin monitor.
module tb_spi_master_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic        lsb_first = 1'b0, loopback = 1'b0;
  logic [7:0]  clk_div = 8'd0;
  logic [5:0]  word_len = 6'd8;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_pop, rx_push, busy, done_intr, rx_overrun;
  logic        rx_full = 1'b0;
  logic [31:0] rx_data;
  logic        spi_sclk, spi_mosi;
  logic        spi_miso = 1'b0;

  int tests = 0, fails = 0;
  int cyc = 0, edges = 0, e1 = 0, e2 = 0, last_edge = 0;
  int pops = 0, dones = 0, pushes = 0, overs = 0, min_gap = 1000;
  logic [31:0] mosi_log = '0;
  logic        sclk_prev = 1'b0;
  logic        miso_on = 1'b0;
  logic [31:0] miso_word = '0;
  int          miso_idx = 0;
  logic [31:0] txq[$];
  logic [31:0] rxq[$];

  spi_master_engine #(.MAX_WORD_LEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cpol       (cpol),
    .cpha       (cpha),
    .lsb_first  (lsb_first),
    .loopback   (loopback),
    .clk_div    (clk_div),
    .word_len   (word_len),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_pop     (tx_pop),
    .rx_full    (rx_full),
    .rx_data    (rx_data),
    .rx_push    (rx_push),
    .busy       (busy),
    .done_intr  (done_intr),
    .rx_overrun (rx_overrun),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (tx_pop && txq.size() != 0) void'(txq.pop_front());

  always @(negedge clk) begin
    cyc++;
    if (spi_sclk !== sclk_prev) begin
      edges++;
      if (edges == 1) e1 = cyc;
      if (edges == 2) e2 = cyc;
      if (spi_sclk) mosi_log = {mosi_log[30:0], spi_mosi};
      if (!spi_sclk && miso_on && miso_idx < 32) begin
        spi_miso = miso_word[miso_idx];
        miso_idx++;
      end
      last_edge = cyc;
    end
    sclk_prev = spi_sclk;
    if (tx_pop) begin
      if (pops > 0 && (cyc - last_edge) < min_gap) min_gap = cyc - last_edge;
      pops++;
    end
    if (done_intr) dones++;
    if (rx_push) begin
      pushes++;
      rxq.push_back(rx_data);
    end
    if (rx_overrun) overs++;
    tx_valid = txq.size() != 0;
    tx_data  = (txq.size() != 0) ? txq[0] : 32'd0;
  end

  task automatic clr();
    edges = 0; pops = 0; dones = 0; pushes = 0; overs = 0;
    min_gap = 1000; mosi_log = '0; rxq.delete();
  endtask

  task automatic cfg(input logic p, input logic h, input logic l,
                     input logic lb, input logic [7:0] d,
                     input logic [5:0] wl);
    cpol = p; cpha = h; lsb_first = l; loopback = lb;
    clk_div = d; word_len = wl;
    repeat (3) @(negedge clk);
    clr();
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (dones == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (dones == 0) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done_intr within %0d cycles", nm, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({spi_sclk, spi_mosi, tx_pop, rx_push, busy, done_intr, rx_overrun} !== 7'd0) begin
      fails++;
      $display("FAIL reset_outs: got %b want 0000000",
               {spi_sclk, spi_mosi, tx_pop, rx_push, busy, done_intr, rx_overrun});
    end
    tests++;
    if (rx_data !== 32'd0) begin
      fails++; $display("FAIL reset_rx: got %h want 0", rx_data);
    end
    rst_n = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_mode0_msb();
    cfg(1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 6'd8);
    txq.push_back(32'hA5);
    wait_done(600, "mode0");
    tests++;
    if (edges !== 16) begin fails++; $display("FAIL m0_edges: got %0d want 16", edges); end
    tests++;
    if (e2 - e1 !== 5) begin fails++; $display("FAIL m0_halfper: got %0d want 5", e2 - e1); end
    tests++;
    if (mosi_log[7:0] !== 8'hA5) begin fails++; $display("FAIL m0_mosi: got %h want a5", mosi_log[7:0]); end
    tests++;
    if (rx_data !== 32'hA5) begin fails++; $display("FAIL m0_rx: got %h want 000000a5", rx_data); end
    tests++;
    if ({pops, pushes, dones} !== {32'd1, 32'd1, 32'd1}) begin
      fails++; $display("FAIL m0_pulses: pop %0d push %0d done %0d want 1 1 1", pops, pushes, dones);
    end
  endtask

  task automatic test_mode3_lsb();
    cfg(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 6'd12);
    tests++;
    if (spi_sclk !== 1'b1) begin fails++; $display("FAIL m3_idle_pre: sclk %b want 1", spi_sclk); end
    miso_word = 32'h5A3; miso_idx = 0; miso_on = 1'b1;
    txq.push_back(32'hFFFF0ABC);
    wait_done(400, "mode3");
    miso_on = 1'b0;
    tests++;
    if (edges !== 24) begin fails++; $display("FAIL m3_edges: got %0d want 24", edges); end
    tests++;
    if (rx_data !== 32'h5A3) begin fails++; $display("FAIL m3_rx: got %h want 000005a3", rx_data); end
    tests++;
    if (spi_sclk !== 1'b1) begin fails++; $display("FAIL m3_idle_post: sclk %b want 1", spi_sclk); end
  endtask

  task automatic test_len_clamp();
    logic [5:0]  wl[3]  = '{6'd0, 6'd40, 6'd32};
    logic [31:0] dat[3] = '{32'h3C, 32'h12345678, 32'hDEADBEEF};
    int          ed[3]  = '{16, 64, 64};
    for (int i = 0; i < 3; i++) begin
      cfg(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, wl[i]);
      txq.push_back(dat[i]);
      wait_done(300, "clamp");
      tests++;
      if (edges !== ed[i]) begin
        fails++; $display("FAIL clamp_edges[%0d]: got %0d want %0d", i, edges, ed[i]);
      end
      tests++;
      if (rx_data !== dat[i]) begin
        fails++; $display("FAIL clamp_rx[%0d]: got %h want %h", i, rx_data, dat[i]);
      end
    end
  endtask

  task automatic test_overrun();
    cfg(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 6'd8);
    rx_full = 1'b1;
    txq.push_back(32'h55);
    wait_done(200, "overrun");
    rx_full = 1'b0;
    tests++;
    if ({overs, dones, pushes} !== {32'd1, 32'd1, 32'd0}) begin
      fails++; $display("FAIL ovr_pulses: ovr %0d done %0d push %0d want 1 1 0", overs, dones, pushes);
    end
    tests++;
    if (rx_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL ovr_hold: got %h want deadbeef", rx_data);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    cfg(1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 6'd8);
    txq.push_back(32'hF0);
    while (edges < 5 && n < 200) begin @(negedge clk); n++; end
    enable = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, spi_sclk} !== 2'b00) begin
      fails++; $display("FAIL abort_idle: busy %b sclk %b want 0 0", busy, spi_sclk);
    end
    repeat (6) @(negedge clk);
    tests++;
    if ({dones, pushes} !== {32'd0, 32'd0}) begin
      fails++; $display("FAIL abort_pulses: done %0d push %0d want 0 0", dones, pushes);
    end
    enable = 1'b1;
    clr();
    txq.push_back(32'h81);
    wait_done(400, "abort_retry");
    tests++;
    if (rx_data !== 32'h81 || pushes !== 1) begin
      fails++; $display("FAIL abort_retry: rx %h push %0d want 00000081 1", rx_data, pushes);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    cfg(1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 6'd8);
    txq.push_back(32'hFF);
    while (edges < 3 && n < 200) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({spi_sclk, spi_mosi, tx_pop, rx_push, busy, done_intr, rx_overrun} !== 7'd0) begin
      fails++;
      $display("FAIL rst_mid_outs: got %b want 0000000",
               {spi_sclk, spi_mosi, tx_pop, rx_push, busy, done_intr, rx_overrun});
    end
    tests++;
    if (rx_data !== 32'd0) begin fails++; $display("FAIL rst_mid_rx: got %h want 0", rx_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3] = '{32'h11, 32'h22, 32'h33};
    int n = 0;
    cfg(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 6'd8);
    for (int i = 0; i < 3; i++) txq.push_back(w[i]);
    while (pushes < 3 && n < 400) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    tests++;
    if (pops !== 3 || rxq.size() !== 3) begin
      fails++; $display("FAIL b2b_count: pops %0d rx %0d want 3 3", pops, rxq.size());
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rxq.size() <= i || rxq[i] !== w[i]) begin
        fails++; $display("FAIL b2b_word[%0d]: got %h want %h", i,
                          (rxq.size() > i) ? rxq[i] : 32'hX, w[i]);
      end
    end
    tests++;
    if (min_gap < 2) begin fails++; $display("FAIL b2b_gap: got %0d want >=2", min_gap); end
  endtask

  initial begin
    test_reset();
    test_mode0_msb();
    test_mode3_lsb();
    test_len_clamp();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
